// File: rtl/imu_ramp_checker.sv
// Sink-side checker for a synthetic ramp sample stream (0..MAX_VALUE, wrapping to 0).
// It locks onto the ramp, predicts each sample, and keeps saturating sample and error counts.
module imu_ramp_checker #(
   parameter int                WIDTH       = 16,
   parameter logic [WIDTH-1:0]  MAX_VALUE   = 16'd500,
   parameter int                LOCK_COUNT  = 4,
   parameter int                UNLOCK_ERRS = 3,
   parameter int                CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_valid,
   input  logic [WIDTH-1:0]     sample_in,
   input  logic                 clear,
   output logic                 locked,
   output logic [1:0]           state,
   output logic [WIDTH-1:0]     expected_out,
   output logic                 err_pulse,
   output logic [CNT_WIDTH-1:0] sample_count,
   output logic [CNT_WIDTH-1:0] error_count
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int EW = $clog2(UNLOCK_ERRS + 1);
   localparam logic [MW-1:0] LOCK_C = MW'(LOCK_COUNT);
   localparam logic [EW-1:0] ERR_C  = EW'(UNLOCK_ERRS);
   localparam logic [MW-1:0] ONE_M  = MW'(1);

   typedef enum logic [1:0] {
      SEARCH  = 2'b00,
      ACQUIRE = 2'b01,
      LOCKED  = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   state_t                st_q, st_d;
   logic [WIDTH-1:0]      exp_q, exp_d;
   logic [MW-1:0]         mc_q, mc_d;
   logic [EW-1:0]         er_q, er_d;
   logic                  pulse_q, pulse_d;
   logic                  locked_q;
   logic [CNT_WIDTH-1:0]  sc_q, sc_d;
   logic [CNT_WIDTH-1:0]  ec_q, ec_d;

   // Ramp successor; anything at or above the peak restarts the ramp at zero.
   function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
      return (x >= MAX_VALUE) ? '0 : x + 1'b1;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      st_d    = st_q;
      exp_d   = exp_q;
      mc_d    = mc_q;
      er_d    = er_q;
      pulse_d = 1'b0;
      sc_d    = sc_q;
      ec_d    = ec_q;
      if (clear) begin
         st_d  = SEARCH;
         exp_d = '0;
         mc_d  = '0;
         er_d  = '0;
         sc_d  = '0;
         ec_d  = '0;
      end else if (sample_valid) begin
         sc_d = sat_inc(sc_q);
         case (st_q)
            SEARCH: begin
               exp_d = nxt(sample_in);
               mc_d  = ONE_M;
               st_d  = ACQUIRE;
            end
            ACQUIRE: begin
               exp_d = nxt(sample_in);
               if (sample_in == exp_q) begin
                  mc_d = mc_q + 1'b1;
                  if (mc_d == LOCK_C) begin
                     st_d = LOCKED;
                     er_d = '0;
                  end
               end else begin
                  mc_d = ONE_M;
               end
            end
            LOCKED: begin
               // Prediction free-runs so a slip keeps producing errors until unlock.
               exp_d = nxt(exp_q);
               if (sample_in == exp_q) begin
                  er_d = '0;
               end else begin
                  pulse_d = 1'b1;
                  ec_d    = sat_inc(ec_q);
                  er_d    = er_q + 1'b1;
                  if (er_d == ERR_C) st_d = SEARCH;
               end
            end
            default: st_d = SEARCH;
         endcase
      end else if (st_q == ILLEGAL) begin
         st_d = SEARCH;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q     <= SEARCH;
         exp_q    <= '0;
         mc_q     <= '0;
         er_q     <= '0;
         pulse_q  <= 1'b0;
         locked_q <= 1'b0;
         sc_q     <= '0;
         ec_q     <= '0;
      end else begin
         st_q     <= st_d;
         exp_q    <= exp_d;
         mc_q     <= mc_d;
         er_q     <= er_d;
         pulse_q  <= pulse_d;
         locked_q <= (st_d == LOCKED);
         sc_q     <= sc_d;
         ec_q     <= ec_d;
      end
   end

   assign state        = st_q;
   assign locked       = locked_q;
   assign expected_out = exp_q;
   assign err_pulse    = pulse_q;
   assign sample_count = sc_q;
   assign error_count  = ec_q;

endmodule
